// File: rtl/normalize_sequencer.sv
// normalize_sequencer: multi-pass left-justification of a 49-bit mantissa.
// A single 31-bit-capped barrel shifter is reused across passes. The shift
// distance is limited so that the biased exponent never drops below 1, which
// makes tiny values come out as subnormals (exponent 0) instead of wrapping.

// Logarithmic left shifter: one mux stage per bit of the shift count.
module left_shifter #(
    parameter int W  = 49,
    parameter int SW = 5
) (
    input  logic [W-1:0]  i_data,
    input  logic [SW-1:0] i_shamt,
    output logic [W-1:0]  o_data
);
    logic [SW:0][W-1:0] w_stage;

    assign w_stage[0] = i_data;

    genvar gi;
    generate
        for (gi = 0; gi < SW; gi++) begin : g_stage
            assign w_stage[gi+1] = i_shamt[gi] ? (w_stage[gi] << (1 << gi)) : w_stage[gi];
        end
    endgenerate

    assign o_data = w_stage[SW];
endmodule

module normalize_sequencer #(
    parameter int EXP_W = 10
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [48:0]      in_mantissa,
    input  logic [EXP_W-1:0] in_exponent,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [48:0]      out_mantissa,
    output logic [EXP_W-1:0] out_exponent,
    output logic [5:0]       out_shift
);
    // Working width for the exponent budget; at least wide enough to hold 48.
    localparam int CW = (EXP_W > 6) ? EXP_W : 6;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_next;

    logic [48:0]      r_work_m;
    logic [48:0]      w_work_m_next;
    logic [EXP_W-1:0] r_work_e;
    logic [EXP_W-1:0] w_work_e_next;
    logic [5:0]       r_total;
    logic [5:0]       w_total_next;

    logic [48:0]      r_out_m;
    logic [48:0]      w_out_m_next;
    logic [EXP_W-1:0] r_out_e;
    logic [EXP_W-1:0] w_out_e_next;
    logic [5:0]       r_out_s;
    logic [5:0]       w_out_s_next;

    logic [5:0]       w_lz;
    logic [CW-1:0]    w_e_ext;
    logic [CW-1:0]    w_e_minus1;
    logic [5:0]       w_budget;
    logic [5:0]       w_step;
    logic [48:0]      w_shifted;

    // Leading-zero count of the working mantissa; 49 only for an all-zero
    // value, which never reaches the SHIFT state.
    always_comb begin
        w_lz = 6'd49;
        for (int i = 0; i < 49; i++) begin
            if (r_work_m[i]) begin
                w_lz = 6'(48 - i);
            end
        end
    end

    assign w_e_ext    = CW'(r_work_e);
    assign w_e_minus1 = w_e_ext - CW'(1);

    // Remaining exponent headroom: shifting further would push it below 1.
    always_comb begin
        if (w_e_ext == '0) begin
            w_budget = 6'd0;
        end else if (w_e_minus1 > CW'(48)) begin
            w_budget = 6'd48;
        end else begin
            w_budget = 6'(w_e_minus1);
        end
    end

    // Per-pass step: smallest of leading zeros, exponent headroom and 31.
    always_comb begin
        w_step = w_lz;
        if (w_budget < w_step) begin
            w_step = w_budget;
        end
        if (w_step > 6'd31) begin
            w_step = 6'd31;
        end
    end

    // The step never exceeds 31, so its low five bits are the full count.
    left_shifter #(
        .W  (49),
        .SW (5)
    ) u_shifter (
        .i_data  (r_work_m),
        .i_shamt (w_step[4:0]),
        .o_data  (w_shifted)
    );

    // Next-state and datapath decisions; everything holds by default.
    always_comb begin
        w_state_next  = r_state;
        w_work_m_next = r_work_m;
        w_work_e_next = r_work_e;
        w_total_next  = r_total;
        w_out_m_next  = r_out_m;
        w_out_e_next  = r_out_e;
        w_out_s_next  = r_out_s;

        case (r_state)
            ST_IDLE: begin
                if (in_valid) begin
                    w_work_m_next = in_mantissa;
                    w_work_e_next = in_exponent;
                    w_total_next  = 6'd0;
                    if (in_mantissa == 49'd0) begin
                        // Zero has nothing to justify: report it directly.
                        w_state_next = ST_DONE;
                        w_out_m_next = 49'd0;
                        w_out_e_next = '0;
                        w_out_s_next = 6'd0;
                    end else begin
                        w_state_next = ST_SHIFT;
                    end
                end
            end

            ST_SHIFT: begin
                if (w_step != 6'd0) begin
                    w_work_m_next = w_shifted;
                    w_work_e_next = r_work_e - EXP_W'(w_step);
                    w_total_next  = r_total + w_step;
                end else begin
                    // Either bit 48 is set or the exponent has bottomed out.
                    w_state_next = ST_DONE;
                    w_out_m_next = r_work_m;
                    w_out_s_next = r_total;
                    w_out_e_next = r_work_m[48] ? r_work_e : '0;
                end
            end

            ST_DONE: begin
                if (out_ready) begin
                    w_state_next = ST_IDLE;
                end
            end

            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // State register; reset abandons any operand in flight.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Working and output registers.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_work_m <= 49'd0;
            r_work_e <= '0;
            r_total  <= 6'd0;
            r_out_m  <= 49'd0;
            r_out_e  <= '0;
            r_out_s  <= 6'd0;
        end else begin
            r_work_m <= w_work_m_next;
            r_work_e <= w_work_e_next;
            r_total  <= w_total_next;
            r_out_m  <= w_out_m_next;
            r_out_e  <= w_out_e_next;
            r_out_s  <= w_out_s_next;
        end
    end

    assign in_ready     = (r_state == ST_IDLE);
    assign out_valid    = (r_state == ST_DONE);
    assign out_mantissa = r_out_m;
    assign out_exponent = r_out_e;
    assign out_shift    = r_out_s;
endmodule
